sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of N active-low seven-segment digits. All digits share a single BCD-to-seven-segment decoder. Each cycle the block presents one digit's 4-bit code on the shared BCD bus and drives that digit's active-low anode, with a dead-time blank between slots to prevent ghosting. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
N_DIG, 4, number of digits scanned; must be at least 2.
DIV, 50000, clock cycles per digit slot; must be at least 2.
DEAD, 16, blank cycles at the start of each slot (anodes all off); must satisfy 0 <= DEAD < DIV.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
load  input  1  one-cycle strobe that captures digits_in into the shadow register
digits_in  input  4*N_DIG  digit codes; digit i is at [4i+3:4i]; all 16 codes pass through unmodified (A=0xA, L=0xB)
dig_en  input  N_DIG  per-digit enable, sampled live each cycle; 0 means the anode is held off
BCD  output  4  code for the shared decoder
an  output  N_DIG  anode drive, active-low, one-cold
frame_done  output  1  one-cycle pulse when the last slot ends

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high.
- Reset values: cnt=0, idx=0, shadow=0, active=0, pending=0, BCD=4'hF, an=all ones, frame_done=0. Asserting rst mid-slot blanks all anodes immediately and discards any pending load.
- Slot counter (width $clog2(DIV)):
  - cnt increments every cycle.
  - At cnt==DIV-1: cnt wraps to 0 and idx advances; idx==N_DIG-1 wraps to 0.
  - That same wrap cycle is the frame boundary.
- Frame boundary cycle:
  - frame_done is registered high for exactly one cycle.
  - If load is high in this cycle, active<=digits_in (bypass), shadow<=digits_in, pending<=0.
  - Otherwise, if pending is set, active<=shadow and pending<=0.
- load outside a boundary: shadow<=digits_in and pending<=1. A later load before the boundary overwrites the shadow; last write wins.
- Output timing: BCD and an are registered and decoded from the current cnt/idx/active/dig_en, so they appear one clock after the counter state.
  - an[idx]=0 only when cnt>=DEAD and dig_en[idx]=1. All other an bits are 1, and all bits are 1 during dead time.
  - BCD=active[idx] for the whole slot, including dead time, so the segments settle before the anode turns on.
  - BCD=4'hF if dig_en[idx]=0.
- At most one an bit is ever low. an is never low during cnt<DEAD.
- dig_en deasserted mid-slot turns the anode off on the next clock. idx keeps advancing regardless of dig_en; disabled slots are not skipped, so refresh timing stays constant.
- Frame period is N_DIG*DIV cycles, and frame_done has exactly that period.

Test Plan:
All scenarios use N_DIG=4, DIV=8, DEAD=2.
1. Reset then release; all dig_en=1, active=0 → an=1111 and BCD=0 on edges 1-2; an=1110 on edges 3-8; an=1111 on edges 9-10; an=1101 on edges 11-16; frame_done pulses every 32 cycles.
2. Pulse load with digits_in=16'hBA98 mid-frame → BCD stays 0 until the next frame_done, then shows 8, 9, A, B in slots 0-3; an is never low during dead time.
3. load coincident with the frame boundary, digits_in=16'h4321 → slot 0 of the very next frame shows BCD=1 (bypass); pending=0 afterwards.
4. Two loads in one frame (16'h1111, then 16'h2222) → next frame shows 2 on every digit; 1 never appears.
5. dig_en=4'b1011 → slot 2 shows an=1111 and BCD=F for all 8 cycles; slot 3 starts on schedule at cycle 24.
6. Assert rst while an=1011 → an=1111 asynchronously, before the next clk edge; after release, scanning restarts from idx 0 and the pending shadow is lost.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
//   Time-multiplexed scan controller for N_DIG active-low seven-segment
//   digits sharing a single BCD decoder. Each digit gets a slot of DIV
//   cycles. The first DEAD cycles of every slot are blanked to prevent
//   ghosting. Display values are double-buffered and committed only at
//   frame boundaries.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   load       one-cycle strobe capturing digits_in into the shadow buffer
//   digits_in  digit codes, digit i at [4i+3:4i]
//   dig_en     per-digit enable, sampled live; 0 holds that anode off
//   BCD        code for the shared decoder (registered)
//   an         active-low, one-cold anode drive (registered)
//   frame_done one-cycle pulse after the last slot of a frame ends
module sseg_scan_ctrl #(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int DEAD  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [4*N_DIG-1:0]   digits_in,
  input  logic [N_DIG-1:0]     dig_en,
  output logic [3:0]           BCD,
  output logic [N_DIG-1:0]     an,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(N_DIG);

  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [4*N_DIG-1:0] shadow;
  logic [4*N_DIG-1:0] active;
  logic               pending;

  logic               cnt_last;
  logic               idx_last;
  logic               boundary;
  logic [3:0]         digit [N_DIG];
  logic [3:0]         bcd_next;
  logic [N_DIG-1:0]   an_next;

  assign cnt_last = (cnt == CNT_W'(DIV - 1));
  assign idx_last = (idx == IDX_W'(N_DIG - 1));
  assign boundary = cnt_last && idx_last;

  always_comb begin
    for (int unsigned i = 0; i < N_DIG; i++) begin
      digit[i] = active[4*i +: 4];
    end
  end

  // BCD is presented for the whole slot (dead time included) so the
  // segments settle before the anode turns on.
  always_comb begin
    an_next  = '1;
    bcd_next = 4'hF;
    if (dig_en[idx]) begin
      bcd_next = digit[idx];
      if (cnt >= CNT_W'(DEAD)) begin
        an_next[idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      BCD        <= 4'hF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      BCD        <= bcd_next;
      an         <= an_next;
      frame_done <= boundary;

      if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A load landing exactly on the boundary bypasses the shadow so the
      // new value is visible in the very next frame.
      if (boundary) begin
        if (load) begin
          active  <= digits_in;
          shadow  <= digits_in;
          pending <= 1'b0;
        end else if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (load) begin
        shadow  <= digits_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl
//   Bench for sseg_scan_ctrl with N_DIG=4, DIV=8, DEAD=2. Outputs are
//   predicted from the elapsed cycle count since reset and a simple
//   frame-level buffer model.
module tb_sseg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = N * DIV;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dig_en;
  logic [3:0]  BCD;
  logic [3:0]  an;
  logic        frame_done;

  sseg_scan_ctrl #(.N_DIG(N), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .dig_en     (dig_en),
    .BCD        (BCD),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: elapsed cycles since reset release plus buffers.
  int unsigned t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic [3:0]  en_cur;

  typedef struct {
    logic        ld;
    logic [15:0] din;
    logic [3:0]  en;
    logic [3:0]  exp_an;
    logic [3:0]  exp_bcd;
    logic        exp_fd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] e);
    int         pos;
    int         slot;
    logic [3:0] ean;
    logic [3:0] ebcd;
    logic       efd;
    @(negedge clk);
    load      = ld;
    digits_in = d;
    dig_en    = e;
    pos  = int'(t % DIV);
    slot = int'((t / DIV) % N);
    ean  = 4'hF;
    if (pos >= DEAD && e[slot]) ean[slot] = 1'b0;
    ebcd = e[slot] ? m_active[slot*4 +: 4] : 4'hF;
    efd  = ((t % FRAME) == FRAME - 1);
    if (efd) begin
      if (ld) begin
        m_active  = d;
        m_shadow  = d;
        m_pending = 1'b0;
      end else if (m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
    end else if (ld) begin
      m_shadow  = d;
      m_pending = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
    chk("an", 16'(an), 16'(ean));
    chk("bcd", 16'(BCD), 16'(ebcd));
    chk("frame_done", 16'(frame_done), 16'(efd));
    chk("one_cold", 16'($countones(~an) <= 1), 16'd1);
  endtask

  task automatic run_to(input int unsigned p);
    while ((t % FRAME) != p) step(1'b0, 16'h0, en_cur);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d got=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{ld: 1'b0, din: 16'h0, en: 4'hF,
                 exp_an: (i < 2 || (i >= 8 && i < 10)) ? 4'hF : ((i < 8) ? 4'hE : 4'hD),
                 exp_bcd: 4'h0, exp_fd: 1'b0};
    end

    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dig_en    = 4'hF;
    en_cur    = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_bcd", 16'(BCD), 16'hF);
    chk("rst_fd", 16'(frame_done), 16'h0);
    rst = 1'b0;

    // Scan timing right after reset.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ld, tbl[i].din, tbl[i].en);
      chk("tbl_an", 16'(an), 16'(tbl[i].exp_an));
      chk("tbl_bcd", 16'(BCD), 16'(tbl[i].exp_bcd));
      chk("tbl_fd", 16'(frame_done), 16'(tbl[i].exp_fd));
    end

    // Mid-frame load waits for the boundary.
    step(1'b1, 16'hBA98, en_cur);
    run_to(31);
    step(1'b0, 16'h0, en_cur);
    chk("t2_fd", 16'(frame_done), 16'h1);
    step(1'b0, 16'h0, en_cur);
    chk("t2_slot0", 16'(BCD), 16'h8);
    for (int s = 1; s < 4; s++) begin
      run_to(s * DIV);
      step(1'b0, 16'h0, en_cur);
      chk("t2_slot", 16'(BCD), 16'(8 + s));
    end

    // Load on the boundary bypasses the shadow.
    run_to(12);
    step(1'b1, 16'h9999, en_cur);
    run_to(31);
    step(1'b1, 16'h4321, en_cur);
    step(1'b0, 16'h0, en_cur);
    chk("t3_bypass", 16'(BCD), 16'h1);
    run_to(31);
    step(1'b0, 16'h0, en_cur);
    step(1'b0, 16'h0, en_cur);
    chk("t3_no_pending", 16'(BCD), 16'h1);

    // Last load in a frame wins.
    run_to(5);
    step(1'b1, 16'h1111, en_cur);
    run_to(15);
    step(1'b1, 16'h2222, en_cur);
    run_to(31);
    step(1'b0, 16'h0, en_cur);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 16'h0, en_cur);
      chk("t4_digit", 16'(BCD), 16'h2);
    end

    // Disabled digit keeps its slot but stays dark.
    en_cur = 4'b1011;
    run_to(16);
    step(1'b0, 16'h0, en_cur);
    chk("t5_off_an", 16'(an), 16'hF);
    chk("t5_off_bcd", 16'(BCD), 16'hF);
    run_to(26);
    step(1'b0, 16'h0, en_cur);
    chk("t5_slot3_an", 16'(an), 16'h7);
    run_to(0);
    en_cur = 4'hF;

    // Asynchronous reset mid-slot discards pending load.
    run_to(10);
    step(1'b1, 16'h7777, en_cur);
    run_to(20);
    step(1'b0, 16'h0, en_cur);
    chk("t6_pre_an", 16'(an), 16'hB);
    #2 rst = 1'b1;
    load = 1'b0;
    #1;
    chk("t6_async_an", 16'(an), 16'hF);
    chk("t6_async_bcd", 16'(BCD), 16'hF);
    chk("t6_async_fd", 16'(frame_done), 16'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    run_to(31);
    step(1'b0, 16'h0, en_cur);
    step(1'b0, 16'h0, en_cur);
    chk("t6_lost_pending", 16'(BCD), 16'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       ld;
      logic [15:0] d;
      ld = (($urandom % 8) == 0);
      d  = 16'($urandom);
      if (($urandom % 16) == 0) en_cur = 4'($urandom);
      step(ld, d, en_cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
